axis_stall_detector: RTL and testbench
======================================

// Module: axis_stall_detector
// PURPOSE
//   Produces the per-channel AXI-Stream block signals consumed by the deadlock monitor.
//   Watches the valid/ready pair of each top-level AXIS channel of the kernel.
//   Flags a channel as blocked once it has stalled for STALL_THRESH consecutive cycles.
//   Latches which channel blocked first and counts block events; sits in the simulation
//   testbench between the DUT's AXIS ports and the deadlock monitor.
// PARAMETERS
//   NUM_CH        2     number of AXIS channels watched (>=1)
//   DIR_MASK      2'b01 per channel: 1 = DUT consumes (input), 0 = DUT produces (output)
//   STALL_THRESH  1024  consecutive stall cycles before block (2..2**CNT_W-1)
//   CNT_W         16    stall counter width
//   EVT_W         8     block event counter width
// PORTS
//   clock            in   1            rising-edge clock
//   reset            in   1            synchronous, active-high
//   enable           in   1            1 = monitoring active; 0 = flush to idle
//   ch_tvalid        in   NUM_CH       TVALID of each channel
//   ch_tready        in   NUM_CH       TREADY of each channel
//   clear_report     in   1            clears the first-block latch and the event counter
//   axis_block_sigs  out  NUM_CH       1 = channel currently blocked (to the monitor)
//   first_valid      out  1            sticky: a block has occurred since the last clear
//   first_ch         out  $clog2(NUM_CH) (min 1)  index of the first blocked channel
//   block_events     out  EVT_W        count of IDLE/WAIT->BLOCKED transitions, saturating
// BEHAVIOUR
//   - Reset: every output is 0, every counter is 0, every channel FSM is IDLE.
//   - Stall condition per channel i:
//       DIR_MASK[i]=1: stall = tready & ~tvalid (DUT starved)
//       DIR_MASK[i]=0: stall = tvalid & ~tready (DUT back-pressured)
//   - Handshake: tvalid & tready. A handshake is never a stall.
//   - Per-channel FSM:
//       IDLE    -> WAIT on stall; cnt <= 1
//       WAIT    -> stall & cnt==STALL_THRESH-1: BLOCKED; stall otherwise: cnt++;
//                  no stall: IDLE, cnt <= 0
//       BLOCKED -> stays while stall; no stall or handshake: IDLE, cnt <= 0
//   - axis_block_sigs[i] is registered as (state==BLOCKED).
//     Rises on the clock edge ending the STALL_THRESH-th consecutive stall cycle.
//     Falls one cycle after the stall condition drops.
//   - The counter never wraps: it is bounded by STALL_THRESH-1 and held in BLOCKED.
//   - enable=0: all FSMs go to IDLE, counters clear, axis_block_sigs=0 next cycle.
//     first_valid, first_ch and block_events are retained.
//   - First-block latch: on a cycle with first_valid=0 and any channel entering BLOCKED:
//     first_valid<=1, first_ch<=lowest such index. Later blocks do not change it.
//   - block_events += number of channels entering BLOCKED that cycle; saturates at all-ones.
//   - clear_report: first_valid, first_ch and block_events <= 0.
//     Takes priority over a same-cycle latch or increment. FSMs are unaffected.
//   - Reset asserted mid-stall: returns to the reset state next edge, no partial count kept.
// STRUCTURE
//   - Package deadlock_mon_pkg:
//       stall_state_t enum {IDLE, WAIT, BLOCKED} (2-bit)
//       helper function is_stall(dir, valid, ready)
//   - Sub-module axis_stall_chan: one channel's FSM and counter.
//     Ports: clock, reset, enable, dir, tvalid, tready, blocked, enter_blocked.
//   - Top level: generate loop of NUM_CH axis_stall_chan instances,
//     priority encoder for first_ch, adder plus saturation for block_events.
// TESTING (NUM_CH=2, DIR_MASK=2'b01, STALL_THRESH=8)
//   1. ch0 tready=1,tvalid=0 held 8 cycles -> axis_block_sigs=01 after 8th edge,
//      first_valid=1, first_ch=0, block_events=1; 7 cycles then handshake -> never blocks
//   2. ch1 tvalid=1,tready=0 held 20 cycles -> block bit 1 high from edge 8 to 20;
//      tready=1 -> bit low next cycle, event count +1 only
//   3. both channels stall starting the same cycle -> both bits rise same edge,
//      first_ch=0, block_events=2
//   4. ch0 stalled 5 cycles, enable=0 for 1 cycle, stall resumes -> block at 8
//      new cycles, not 3
//   5. block_events preset to 255 via repeated blocks -> another block keeps 255;
//      clear_report with a same-cycle block -> 0, first_valid=0
//   6. reset pulsed while ch1 BLOCKED -> all outputs 0 next cycle;
//      stall kept -> re-blocks after 8 cycles

Source files
------------

// File: rtl/deadlock_mon_pkg.sv
// Shared types and helpers for the AXI-Stream stall detector.
// The stall rule depends on which side of the channel the kernel sits.
package deadlock_mon_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    BLOCKED = 2'd2
  } stall_state_t;

  // dir=1: kernel consumes, so it stalls when starved.
  // dir=0: kernel produces, so it stalls when back-pressured.
  function automatic logic is_stall(input logic dir, input logic valid, input logic ready);
    return dir ? (ready & ~valid) : (valid & ~ready);
  endfunction

endpackage

// File: rtl/axis_stall_detector_if.sv
// Bundle of the watched TVALID/TREADY pairs, one bit per AXIS channel.
interface axis_stall_detector_if #(
  parameter int NUM_CH = 2
);
  logic [NUM_CH-1:0] ch_tvalid;
  logic [NUM_CH-1:0] ch_tready;

  modport master (output ch_tvalid, output ch_tready);
  modport slave  (input  ch_tvalid, input  ch_tready);
endinterface

// File: rtl/axis_stall_chan.sv
// One channel's stall tracker: counts consecutive stall cycles and
// reports BLOCKED once the run reaches STALL_THRESH cycles.
module axis_stall_chan
  import deadlock_mon_pkg::*;
#(
  parameter int CNT_W        = 16,
  parameter int STALL_THRESH = 1024
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  input  logic dir,
  input  logic tvalid,
  input  logic tready,
  output logic blocked,
  output logic enter_blocked
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STALL_THRESH - 1);

  stall_state_t      state, state_next;
  logic [CNT_W-1:0]  cnt, cnt_next;
  logic              stall;

  assign stall = is_stall(dir, tvalid, tready);

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // The count freezes at LAST_CNT while BLOCKED, so it can never wrap.
  always_comb begin
    state_next    = state;
    cnt_next      = cnt;
    enter_blocked = 1'b0;
    if (!enable) begin
      state_next = IDLE;
      cnt_next   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (stall) begin
            state_next = WAIT;
            cnt_next   = CNT_W'(1);
          end
        end
        WAIT: begin
          if (!stall) begin
            state_next = IDLE;
            cnt_next   = '0;
          end else if (cnt == LAST_CNT) begin
            state_next    = BLOCKED;
            enter_blocked = 1'b1;
          end else begin
            cnt_next = cnt + CNT_W'(1);
          end
        end
        BLOCKED: begin
          if (!stall) begin
            state_next = IDLE;
            cnt_next   = '0;
          end
        end
        default: begin
          state_next = IDLE;
          cnt_next   = '0;
        end
      endcase
    end
  end

  assign blocked = (state == BLOCKED);

endmodule

// File: rtl/axis_stall_detector.sv
// Watches every top-level AXIS channel of the kernel, drives the per-channel
// block signals for the deadlock monitor, and keeps a first-block report.
module axis_stall_detector
  import deadlock_mon_pkg::*;
#(
  parameter int                NUM_CH       = 2,
  parameter logic [NUM_CH-1:0] DIR_MASK     = NUM_CH'(2'b01),
  parameter int                STALL_THRESH = 1024,
  parameter int                CNT_W        = 16,
  parameter int                EVT_W        = 8,
  localparam int               CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  axis_stall_detector_if.slave  axis,
  input  logic                  clear_report,
  output logic [NUM_CH-1:0]     axis_block_sigs,
  output logic                  first_valid,
  output logic [CH_W-1:0]       first_ch,
  output logic [EVT_W-1:0]      block_events
);

  localparam int ECW   = $clog2(NUM_CH + 1);
  localparam int SUM_W = EVT_W + ECW;
  localparam logic [SUM_W-1:0] EVT_MAX = SUM_W'({EVT_W{1'b1}});

  logic [NUM_CH-1:0] enter;
  logic [CH_W-1:0]   first_idx;
  logic [ECW-1:0]    enter_cnt;
  logic [SUM_W-1:0]  sum;
  logic [EVT_W-1:0]  events_next;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
    axis_stall_chan #(
      .CNT_W        (CNT_W),
      .STALL_THRESH (STALL_THRESH)
    ) u_chan (
      .clock         (clock),
      .reset         (reset),
      .enable        (enable),
      .dir           (DIR_MASK[i]),
      .tvalid        (axis.ch_tvalid[i]),
      .tready        (axis.ch_tready[i]),
      .blocked       (axis_block_sigs[i]),
      .enter_blocked (enter[i])
    );
  end

  // Lowest entering index wins; several channels may block on the same edge.
  always_comb begin
    first_idx = '0;
    enter_cnt = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (enter[i]) first_idx = CH_W'(i);
    end
    for (int i = 0; i < NUM_CH; i++) begin
      enter_cnt = enter_cnt + ECW'(enter[i]);
    end
    sum         = SUM_W'(block_events) + SUM_W'(enter_cnt);
    events_next = (sum > EVT_MAX) ? {EVT_W{1'b1}} : sum[EVT_W-1:0];
  end

  always_ff @(posedge clock) begin
    if (reset || clear_report) begin
      first_valid  <= 1'b0;
      first_ch     <= '0;
      block_events <= '0;
    end else begin
      if (!first_valid && (|enter)) begin
        first_valid <= 1'b1;
        first_ch    <= first_idx;
      end
      block_events <= events_next;
    end
  end

endmodule

// File: tb/tb_axis_stall_detector.sv
// Directed scoreboard bench for axis_stall_detector (2 channels, threshold 8).
module tb_axis_stall_detector;

  typedef struct packed {
    logic [1:0] blk;
    logic       fv;
    logic       fc;
    logic [7:0] ev;
  } exp_t;

  logic       clock = 1'b0;
  logic       reset;
  logic       enable;
  logic       clear_report;
  logic [1:0] axis_block_sigs;
  logic       first_valid;
  logic [0:0] first_ch;
  logic [7:0] block_events;

  exp_t  exp_q[$];
  string name_q[$];
  int    checks = 0;
  int    passed = 0;

  axis_stall_detector_if #(.NUM_CH(2)) axis ();

  axis_stall_detector #(
    .NUM_CH       (2),
    .DIR_MASK     (2'b01),
    .STALL_THRESH (8),
    .CNT_W        (16),
    .EVT_W        (8)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .enable          (enable),
    .axis            (axis.slave),
    .clear_report    (clear_report),
    .axis_block_sigs (axis_block_sigs),
    .first_valid     (first_valid),
    .first_ch        (first_ch),
    .block_events    (block_events)
  );

  always #5 clock = ~clock;

  // Each pushed expectation describes the outputs after the next rising edge.
  always @(posedge clock) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t  e;
      exp_t  got;
      string nm;
      e   = exp_q.pop_front();
      nm  = name_q.pop_front();
      got = '{blk: axis_block_sigs, fv: first_valid, fc: first_ch[0], ev: block_events};
      checks++;
      if (got === e) passed++;
      else $display("[TB] FAIL %s: got blk=%b fv=%b fc=%b ev=%0d, expected blk=%b fv=%b fc=%b ev=%0d",
                    nm, got.blk, got.fv, got.fc, got.ev, e.blk, e.fv, e.fc, e.ev);
    end
  end

  task automatic applyStimulus(input logic [1:0] v, input logic [1:0] r,
                               input logic en, input logic clr, input logic rst,
                               input logic [1:0] eb, input logic efv, input logic efc,
                               input logic [7:0] eev, input string nm);
    @(negedge clock);
    axis.ch_tvalid = v;
    axis.ch_tready = r;
    enable         = en;
    clear_report   = clr;
    reset          = rst;
    exp_q.push_back('{blk: eb, fv: efv, fc: efc, ev: eev});
    name_q.push_back(nm);
  endtask

  // Eight stall cycles then one idle cycle; report flags already set.
  task automatic blockRun(input logic [1:0] v, input logic [1:0] r, input logic [1:0] blk,
                          input logic [7:0] ev_before, input logic [7:0] ev_after,
                          input string nm);
    for (int k = 1; k <= 8; k++)
      applyStimulus(v, r, 1'b1, 1'b0, 1'b0, (k == 8) ? blk : 2'b00, 1'b1, 1'b0,
                    (k == 8) ? ev_after : ev_before, nm);
    applyStimulus(2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, ev_after, {nm, "_idle"});
  endtask

  initial begin
    axis.ch_tvalid = 2'b00;
    axis.ch_tready = 2'b00;
    enable         = 1'b1;
    clear_report   = 1'b0;
    reset          = 1'b1;

    applyStimulus(2'b00, 2'b00, 1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 8'd0, "reset_0");
    applyStimulus(2'b00, 2'b00, 1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 8'd0, "reset_1");

    // ch0 starved for exactly the threshold
    for (int k = 1; k <= 8; k++)
      applyStimulus(2'b00, 2'b01, 1'b1, 1'b0, 1'b0, (k == 8) ? 2'b01 : 2'b00,
                    k == 8, 1'b0, (k == 8) ? 8'd1 : 8'd0, "t1_ch0_block");
    applyStimulus(2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 8'd1, "t1_ch0_fall");
    // one short of the threshold, then a handshake
    for (int k = 1; k <= 7; k++)
      applyStimulus(2'b00, 2'b01, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 8'd1, "t1_ch0_seven");
    applyStimulus(2'b01, 2'b01, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 8'd1, "t1_handshake");
    applyStimulus(2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 8'd1, "t1_after_hs");

    applyStimulus(2'b00, 2'b00, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 8'd0, "clear_a");

    // ch1 back-pressured for 20 cycles
    for (int k = 1; k <= 20; k++)
      applyStimulus(2'b10, 2'b00, 1'b1, 1'b0, 1'b0, (k >= 8) ? 2'b10 : 2'b00,
                    k >= 8, k >= 8, (k >= 8) ? 8'd1 : 8'd0, "t2_ch1_hold");
    applyStimulus(2'b10, 2'b10, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 8'd1, "t2_ch1_release");
    applyStimulus(2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 8'd1, "t2_idle");

    applyStimulus(2'b00, 2'b00, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 8'd0, "clear_b");

    // both channels stall together
    for (int k = 1; k <= 8; k++)
      applyStimulus(2'b10, 2'b01, 1'b1, 1'b0, 1'b0, (k == 8) ? 2'b11 : 2'b00,
                    k == 8, 1'b0, (k == 8) ? 8'd2 : 8'd0, "t3_both");
    applyStimulus(2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 8'd2, "t3_idle");

    // enable drop mid-stall restarts the count
    for (int k = 1; k <= 5; k++)
      applyStimulus(2'b00, 2'b01, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 8'd2, "t4_pre");
    applyStimulus(2'b00, 2'b01, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 8'd2, "t4_disable");
    for (int k = 1; k <= 8; k++)
      applyStimulus(2'b00, 2'b01, 1'b1, 1'b0, 1'b0, (k == 8) ? 2'b01 : 2'b00,
                    1'b1, 1'b0, (k == 8) ? 8'd3 : 8'd2, "t4_resume");
    applyStimulus(2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 8'd3, "t4_idle");

    // fill the event counter up to 253, then cross the saturation point
    for (int j = 1; j <= 125; j++)
      blockRun(2'b10, 2'b01, 2'b11, 8'(3 + 2 * (j - 1)), 8'(3 + 2 * j), "t5_fill");
    blockRun(2'b00, 2'b01, 2'b01, 8'd253, 8'd254, "t5_to254");
    blockRun(2'b10, 2'b01, 2'b11, 8'd254, 8'd255, "t5_saturate");
    blockRun(2'b00, 2'b01, 2'b01, 8'd255, 8'd255, "t5_hold255");

    // clear wins over a same-cycle block
    for (int k = 1; k <= 7; k++)
      applyStimulus(2'b10, 2'b01, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 8'd255, "t5_pre_clear");
    applyStimulus(2'b10, 2'b01, 1'b1, 1'b1, 1'b0, 2'b11, 1'b0, 1'b0, 8'd0, "t5_clear_vs_block");
    applyStimulus(2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 8'd0, "t5_idle");

    // reset while ch1 is blocked, stall kept through and after reset
    for (int k = 1; k <= 9; k++)
      applyStimulus(2'b10, 2'b00, 1'b1, 1'b0, 1'b0, (k >= 8) ? 2'b10 : 2'b00,
                    k >= 8, k >= 8, (k >= 8) ? 8'd1 : 8'd0, "t6_block");
    applyStimulus(2'b10, 2'b00, 1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 8'd0, "t6_reset");
    for (int k = 1; k <= 8; k++)
      applyStimulus(2'b10, 2'b00, 1'b1, 1'b0, 1'b0, (k == 8) ? 2'b10 : 2'b00,
                    k == 8, k == 8, (k == 8) ? 8'd1 : 8'd0, "t6_reblock");

    // enable drop flushes a blocked channel but keeps the report
    applyStimulus(2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 8'd1, "t6_disable_flush");
    applyStimulus(2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 8'd1, "t6_idle");

    checkOutput();
  end

  task automatic checkOutput();
    for (int n = 0; n < 10 && exp_q.size() > 0; n++) @(negedge clock);
    if (exp_q.size() > 0) begin
      checks++;
      $display("[TB] FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  endtask

endmodule
